// File: rtl/keypad_entry.sv
// keypad_entry: debounces key reports from an upstream keypad scanner and
// assembles the accepted digit keys into a BCD entry, which is handed to a
// consumer through a valid/ready register.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   key_valid    scanner reports a key down
//   key_code     scanner code (0-9 digits, A-D letters, E '*', F '#')
//   key_event    one-cycle pulse per accepted debounced press
//   key_value    code of the last accepted press
//   entry_bcd    digits being typed, newest digit in [3:0]
//   digit_count  number of valid digits in entry_bcd
//   out_valid    completed entry presented on out_bcd/out_count
//   out_ready    consumer accepts the completed entry
//   out_bcd      completed entry, same format as entry_bcd
//   out_count    digit count of the completed entry
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_DIGITS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_event,
  output logic [3:0]  key_value,
  output logic [31:0] entry_bcd,
  output logic [3:0]  digit_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bcd,
  output logic [3:0]  out_count
);

  localparam logic [1:0] WAIT_PRESS   = 2'd0;
  localparam logic [1:0] DB_PRESS     = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;
  localparam logic [1:0] DB_RELEASE   = 2'd3;

  localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  MAX_CNT    = 4'(MAX_DIGITS);
  // Keeps shifted-in digits from growing past MAX_DIGITS nibbles.
  localparam logic [31:0] ENTRY_MASK = 32'hFFFF_FFFF >> (32 - 4 * MAX_DIGITS);

  logic [1:0]  state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  cap_code;
  logic        accept;
  logic [31:0] entry_n, out_bcd_n;
  logic [3:0]  count_n, out_count_n;
  logic        out_valid_n;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Debounce FSM: accept fires on the edge that takes the final matching sample.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      WAIT_PRESS: begin
        if (key_valid) begin
          state_n = DB_PRESS;
          cnt_n   = 8'd1;
        end
      end
      DB_PRESS: begin
        if (key_valid && key_code == cap_code) begin
          if (sat_inc(cnt) >= DB_LAST) begin
            accept  = 1'b1;
            state_n = WAIT_RELEASE;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end else begin
          state_n = WAIT_PRESS;
          cnt_n   = 8'd0;
        end
      end
      WAIT_RELEASE: begin
        if (!key_valid) begin
          state_n = DB_RELEASE;
          cnt_n   = 8'd1;
        end
      end
      DB_RELEASE: begin
        if (!key_valid) begin
          if (sat_inc(cnt) >= DB_LAST) begin
            state_n = WAIT_PRESS;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end else begin
          state_n = WAIT_RELEASE;
          cnt_n   = 8'd0;
        end
      end
      default: begin
        state_n = WAIT_PRESS;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Key actions; the entry is frozen while a completed entry awaits the consumer.
  always_comb begin
    entry_n     = entry_bcd;
    count_n     = digit_count;
    out_valid_n = out_valid;
    out_bcd_n   = out_bcd;
    out_count_n = out_count;
    if (out_valid) begin
      if (out_ready) out_valid_n = 1'b0;
    end else if (accept) begin
      if (cap_code <= 4'h9) begin
        if (digit_count < MAX_CNT) begin
          entry_n = {entry_bcd[27:0], cap_code} & ENTRY_MASK;
          count_n = digit_count + 4'd1;
        end
      end else if (cap_code == 4'hE) begin
        if (digit_count != 4'd0) begin
          entry_n = entry_bcd >> 4;
          count_n = digit_count - 4'd1;
        end
      end else if (cap_code == 4'hC) begin
        entry_n = 32'd0;
        count_n = 4'd0;
      end else if (cap_code == 4'hF) begin
        if (digit_count != 4'd0) begin
          out_bcd_n   = entry_bcd;
          out_count_n = digit_count;
          out_valid_n = 1'b1;
          entry_n     = 32'd0;
          count_n     = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_PRESS;
      cnt         <= 8'd0;
      cap_code    <= 4'd0;
      key_event   <= 1'b0;
      key_value   <= 4'd0;
      entry_bcd   <= 32'd0;
      digit_count <= 4'd0;
      out_valid   <= 1'b0;
      out_bcd     <= 32'd0;
      out_count   <= 4'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      if (state == WAIT_PRESS && key_valid) cap_code <= key_code;
      key_event   <= accept;
      if (accept) key_value <= cap_code;
      entry_bcd   <= entry_n;
      digit_count <= count_n;
      out_valid   <= out_valid_n;
      out_bcd     <= out_bcd_n;
      out_count   <= out_count_n;
    end
  end

endmodule
